// File: rtl/e_alu_arb.sv
// e_alu_arb: round-robin arbiter and two-stage issue/result pipeline that
// shares one external execute-stage ALU between the integer pipe (0) and
// the branch/address unit (1).
module e_alu_arb #(
    parameter logic PRIO_INIT = 1'b0
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_con_Stall,
    input  logic        i_con_Req0,
    input  logic        i_con_Req1,
    input  logic [31:0] i_data_A0,
    input  logic [31:0] i_data_A1,
    input  logic [31:0] i_data_B0,
    input  logic [31:0] i_data_B1,
    input  logic [3:0]  i_con_AluCtrl0,
    input  logic [3:0]  i_con_AluCtrl1,
    input  logic [4:0]  i_data_shamt0,
    input  logic [4:0]  i_data_shamt1,
    output logic        o_con_Gnt0,
    output logic        o_con_Gnt1,
    output logic [31:0] o_data_Res0,
    output logic [31:0] o_data_Res1,
    output logic        o_con_Valid0,
    output logic        o_con_Valid1,
    output logic        o_con_Illegal,
    output logic [31:0] o_alu_A,
    output logic [31:0] o_alu_B,
    output logic [3:0]  o_alu_Ctrl,
    output logic [4:0]  o_alu_shamt,
    input  logic [31:0] i_alu_Res
);

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 4;
    localparam int unsigned SW = 5;

    // Round-robin pointer: names the requester preferred on contention
    logic prio;

    // Issue stage
    logic          v_i;
    logic          src_i;
    logic          ill_i;
    logic [DW-1:0] a_i;
    logic [DW-1:0] b_i;
    logic [CW-1:0] ctrl_i;
    logic [SW-1:0] shamt_i;

    // Result stage
    logic          v_r;
    logic          src_r;
    logic          ill_r;
    logic [DW-1:0] res_r;

    // Combinational arbitration and winner operand selection
    logic          gnt0_c;
    logic          gnt1_c;
    logic          any_gnt_c;
    logic          win_c;
    logic [DW-1:0] win_a_c;
    logic [DW-1:0] win_b_c;
    logic [CW-1:0] win_ctrl_c;
    logic [SW-1:0] win_shamt_c;
    logic          win_ill_c;

    // Grant decision; grants are suppressed during stall and reset
    always_comb begin
        gnt0_c = 1'b0;
        gnt1_c = 1'b0;
        if (i_rst_n && !i_con_Stall) begin
            gnt0_c = i_con_Req0 && (!i_con_Req1 || (prio == 1'b0));
            gnt1_c = i_con_Req1 && (!i_con_Req0 || (prio == 1'b1));
        end
    end

    assign any_gnt_c = gnt0_c | gnt1_c;
    assign win_c     = gnt1_c;

    // Winner operand mux and illegal op code detection (10, 11, 14, 15)
    always_comb begin
        win_a_c     = i_data_A0;
        win_b_c     = i_data_B0;
        win_ctrl_c  = i_con_AluCtrl0;
        win_shamt_c = i_data_shamt0;
        if (win_c) begin
            win_a_c     = i_data_A1;
            win_b_c     = i_data_B1;
            win_ctrl_c  = i_con_AluCtrl1;
            win_shamt_c = i_data_shamt1;
        end
        win_ill_c = (win_ctrl_c == CW'(10)) || (win_ctrl_c == CW'(11)) ||
                    (win_ctrl_c == CW'(14)) || (win_ctrl_c == CW'(15));
    end

    // Pointer moves to the loser after each grant, holds otherwise
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            prio <= PRIO_INIT;
        end else if (any_gnt_c) begin
            prio <= ~win_c;
        end
    end

    // Issue register: captures the winner's operands on a grant edge
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            v_i     <= 1'b0;
            src_i   <= 1'b0;
            ill_i   <= 1'b0;
            a_i     <= '0;
            b_i     <= '0;
            ctrl_i  <= '0;
            shamt_i <= '0;
        end else if (!i_con_Stall) begin
            v_i <= any_gnt_c;
            if (any_gnt_c) begin
                src_i   <= win_c;
                ill_i   <= win_ill_c;
                a_i     <= win_a_c;
                b_i     <= win_b_c;
                ctrl_i  <= win_ctrl_c;
                shamt_i <= win_shamt_c;
            end
        end
    end

    // Result register: samples the shared ALU, forcing 0 for illegal ops
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            v_r   <= 1'b0;
            src_r <= 1'b0;
            ill_r <= 1'b0;
            res_r <= '0;
        end else if (!i_con_Stall) begin
            v_r   <= v_i;
            src_r <= src_i;
            ill_r <= ill_i;
            res_r <= ill_i ? '0 : i_alu_Res;
        end
    end

    assign o_con_Gnt0    = gnt0_c;
    assign o_con_Gnt1    = gnt1_c;
    assign o_alu_A       = a_i;
    assign o_alu_B       = b_i;
    assign o_alu_Ctrl    = ctrl_i;
    assign o_alu_shamt   = shamt_i;
    assign o_data_Res0   = res_r;
    assign o_data_Res1   = res_r;
    assign o_con_Valid0  = v_r & ~src_r & ~i_con_Stall;
    assign o_con_Valid1  = v_r &  src_r & ~i_con_Stall;
    assign o_con_Illegal = v_r &  ill_r & ~i_con_Stall;

endmodule

// File: tb/tb_e_alu_arb.sv
// Directed testbench for e_alu_arb with a behavioural model of the shared ALU.
module tb_e_alu_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        req0, req1;
    logic [31:0] a0, a1, b0, b1;
    logic [3:0]  ctrl0, ctrl1;
    logic [4:0]  sh0, sh1;
    logic        gnt0, gnt1;
    logic [31:0] res0, res1;
    logic        val0, val1, ill;
    logic [31:0] alu_a, alu_b, alu_res;
    logic [3:0]  alu_ctrl;
    logic [4:0]  alu_shamt;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    e_alu_arb #(.PRIO_INIT(1'b0)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_con_Stall(stall),
        .i_con_Req0(req0), .i_con_Req1(req1),
        .i_data_A0(a0), .i_data_A1(a1), .i_data_B0(b0), .i_data_B1(b1),
        .i_con_AluCtrl0(ctrl0), .i_con_AluCtrl1(ctrl1),
        .i_data_shamt0(sh0), .i_data_shamt1(sh1),
        .o_con_Gnt0(gnt0), .o_con_Gnt1(gnt1),
        .o_data_Res0(res0), .o_data_Res1(res1),
        .o_con_Valid0(val0), .o_con_Valid1(val1), .o_con_Illegal(ill),
        .o_alu_A(alu_a), .o_alu_B(alu_b), .o_alu_Ctrl(alu_ctrl),
        .o_alu_shamt(alu_shamt), .i_alu_Res(alu_res)
    );

    // External ALU model; illegal codes return junk that the DUT must zero
    always_comb begin
        case (alu_ctrl)
            4'd0:    alu_res = alu_a & alu_b;
            4'd1:    alu_res = alu_a | alu_b;
            4'd2:    alu_res = alu_a + alu_b;
            4'd3:    alu_res = alu_b << alu_shamt;
            4'd4:    alu_res = alu_b >> alu_shamt;
            4'd5:    alu_res = 32'($signed(alu_b) >>> alu_shamt);
            4'd6:    alu_res = alu_a - alu_b;
            4'd7:    alu_res = {31'd0, alu_a < alu_b};
            4'd8:    alu_res = {alu_b[15:0], 16'd0};
            4'd9:    alu_res = {31'd0, $signed(alu_a) < $signed(alu_b)};
            4'd12:   alu_res = ~(alu_a | alu_b);
            4'd13:   alu_res = alu_a ^ alu_b;
            default: alu_res = 32'hDEADBEEF;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall = 1'b0; req0 = 1'b0; req1 = 1'b0;
        a0 = '0; a1 = '0; b0 = '0; b1 = '0;
        ctrl0 = '0; ctrl1 = '0; sh0 = '0; sh1 = '0;
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1;
        idle_inputs();
        #1 rst_n = 1'b0;
        #1;
        // Reset state
        check("rst_gnt", {30'd0, gnt1, gnt0}, 32'd0);
        check("rst_valid", {29'd0, ill, val1, val0}, 32'd0);
        check("rst_res0", res0, 32'd0);
        check("rst_res1", res1, 32'd0);
        check("rst_alu_a", alu_a, 32'd0);
        check("rst_alu_b", alu_b, 32'd0);
        check("rst_alu_cs", {23'd0, alu_ctrl, alu_shamt}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;

        // Single op: 5 + 3 on requester 0
        req0 = 1'b1; a0 = 32'd5; b0 = 32'd3; ctrl0 = 4'd2;
        #1 check("single_gnt", {30'd0, gnt1, gnt0}, 32'd1);
        tick();
        idle_inputs();
        #1 check("single_c2_val", {30'd0, val1, val0}, 32'd0);
        check("single_alu_a", alu_a, 32'd5);
        check("single_alu_ctrl", {28'd0, alu_ctrl}, 32'd2);
        tick();
        check("single_c3_val", {29'd0, ill, val1, val0}, 32'd1);
        check("single_res0", res0, 32'd8);
        tick();
        check("single_c4_val", {30'd0, val1, val0}, 32'd0);

        // Contention: prio back to 0, both hold for 4 cycles, then one more
        reset_pulse();
        req0 = 1'b1; req1 = 1'b1;
        a0 = 32'd10; b0 = 32'd1; ctrl0 = 4'd6;
        a1 = 32'd10; b1 = 32'd1; ctrl1 = 4'd6;
        #1 check("cont_c1_gnt", {30'd0, gnt1, gnt0}, 32'b01);
        tick();
        check("cont_c2_gnt", {30'd0, gnt1, gnt0}, 32'b10);
        check("cont_c2_val", {30'd0, val1, val0}, 32'b00);
        tick();
        check("cont_c3_gnt", {30'd0, gnt1, gnt0}, 32'b01);
        check("cont_c3_val", {30'd0, val1, val0}, 32'b01);
        check("cont_c3_res", res0, 32'd9);
        tick();
        check("cont_c4_gnt", {30'd0, gnt1, gnt0}, 32'b10);
        check("cont_c4_val", {30'd0, val1, val0}, 32'b10);
        check("cont_c4_res", res1, 32'd9);
        tick();
        check("cont_prio0_gnt", {30'd0, gnt1, gnt0}, 32'b01);
        check("cont_c5_val", {30'd0, val1, val0}, 32'b01);
        tick();
        idle_inputs();
        #1 check("cont_c6_val", {30'd0, val1, val0}, 32'b10);
        tick();
        check("cont_c7_val", {30'd0, val1, val0}, 32'b01);
        tick();
        check("cont_c8_val", {30'd0, val1, val0}, 32'b00);

        // Stall holds the issue stage; requester 0 is blocked while stalled
        req1 = 1'b1; a1 = 32'hFFFF0000; b1 = 32'h0000FFFF; ctrl1 = 4'd1;
        #1 check("stall_c1_gnt", {30'd0, gnt1, gnt0}, 32'b10);
        tick();
        req1 = 1'b0; req0 = 1'b1; stall = 1'b1;
        #1 check("stall_c2_gnt", {30'd0, gnt1, gnt0}, 32'b00);
        check("stall_c2_val", {30'd0, val1, val0}, 32'b00);
        tick();
        check("stall_c3_gnt", {30'd0, gnt1, gnt0}, 32'b00);
        check("stall_c3_alu_a", alu_a, 32'hFFFF0000);
        tick();
        stall = 1'b0; req0 = 1'b0;
        #1 check("stall_c4_val", {30'd0, val1, val0}, 32'b00);
        tick();
        check("stall_c5_val", {30'd0, val1, val0}, 32'b10);
        check("stall_c5_res", res1, 32'hFFFFFFFF);
        tick();
        check("stall_c6_val", {30'd0, val1, val0}, 32'b00);

        // Illegal op code 11: issued, result forced to 0
        req0 = 1'b1; a0 = 32'd7; b0 = 32'd9; ctrl0 = 4'd11;
        #1 check("ill_gnt", {30'd0, gnt1, gnt0}, 32'b01);
        tick();
        idle_inputs();
        #1 check("ill_issued_ctrl", {28'd0, alu_ctrl}, 32'd11);
        tick();
        check("ill_val", {29'd0, ill, val1, val0}, 32'b101);
        check("ill_res", res0, 32'd0);
        tick();
        check("ill_after", {29'd0, ill, val1, val0}, 32'd0);

        // Stall over a pending result: masked, then presented once
        req1 = 1'b1; a1 = 32'h000000F0; b1 = 32'h000000FF; ctrl1 = 4'd13;
        tick();
        idle_inputs();
        tick();
        stall = 1'b1;
        #1 check("pend_masked", {29'd0, ill, val1, val0}, 32'd0);
        tick();
        stall = 1'b0;
        #1 check("pend_val", {29'd0, ill, val1, val0}, 32'b010);
        check("pend_res", res1, 32'h0000000F);
        tick();
        check("pend_after", {30'd0, val1, val0}, 32'd0);

        // Reset mid-flight: ops granted in cycles 1 and 2 are discarded
        req0 = 1'b1; a0 = 32'd1; b0 = 32'd2; ctrl0 = 4'd2;
        #1 check("rmf_c1_gnt", {30'd0, gnt1, gnt0}, 32'b01);
        tick();
        req0 = 1'b0; req1 = 1'b1; a1 = 32'd3; b1 = 32'd4; ctrl1 = 4'd2;
        #1 check("rmf_c2_gnt", {30'd0, gnt1, gnt0}, 32'b10);
        #2 rst_n = 1'b0;
        #1 check("rmf_gnt", {30'd0, gnt1, gnt0}, 32'd0);
        check("rmf_alu_a", alu_a, 32'd0);
        check("rmf_val", {29'd0, ill, val1, val0}, 32'd0);
        tick();
        idle_inputs();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 check("rmf_noval", {29'd0, ill, val1, val0}, 32'd0);
            tick();
        end
        req0 = 1'b1; req1 = 1'b1;
        #1 check("rmf_prio_init", {30'd0, gnt1, gnt0}, 32'b01);
        tick();
        idle_inputs();
        tick();
        tick();

        // slt vs sltu on the same operands, back-to-back from requester 0
        req0 = 1'b1; a0 = 32'hFFFFFFFF; b0 = 32'd1; ctrl0 = 4'd9;
        #1 check("slt_gnt", {30'd0, gnt1, gnt0}, 32'b01);
        tick();
        ctrl0 = 4'd7;
        #1 check("sltu_gnt", {30'd0, gnt1, gnt0}, 32'b01);
        tick();
        idle_inputs();
        #1 check("slt_val", {30'd0, val1, val0}, 32'b01);
        check("slt_res", res0, 32'd1);
        tick();
        check("sltu_val", {30'd0, val1, val0}, 32'b01);
        check("sltu_res", res0, 32'd0);
        tick();
        check("slt_after", {30'd0, val1, val0}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
